// File: rtl/quickq_pkg.sv
// Shared types for the min-priority queue sequencer:
// router modes, FSM states and the empty-slot sentinel.
package quickq_pkg;

  // Wide enough for any supported key width; modules slice it to DW.
  localparam logic [63:0] SENTINEL = '1;

  typedef enum logic [2:0] {
    INS_CMP = 3'b000,
    INS_CMT = 3'b001,
    REM_CMP = 3'b010,
    REM_CMT = 3'b011
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    RD,
    CMP,
    HEAD_RD,
    HEAD,
    CMT,
    RSP
  } state_e;

endpackage

// File: rtl/queue_sequencer_value_router.sv
// Compare/shift datapath for one queue slot plus occupancy update.
// Ports: mode, bram_out, reg_out, array_size, array_cnt_in -> bram_insert, to_register, array_cnt_out.
module valueRouter
  import quickq_pkg::*;
#(
  parameter int DW = 32
) (
  input  mode_e         mode,
  input  logic [DW-1:0] bram_out,
  input  logic [DW-1:0] reg_out,
  input  logic [7:0]    array_size,
  input  logic [7:0]    array_cnt_in,
  output logic [DW-1:0] bram_insert,
  output logic [DW-1:0] to_register,
  output logic [7:0]    array_cnt_out
);

  always_comb begin
    bram_insert   = bram_out;
    to_register   = reg_out;
    array_cnt_out = array_cnt_in;
    unique case (mode)
      INS_CMP: begin
        // Smaller key stays in the slot, larger one ripples on.
        if (reg_out < bram_out) begin
          bram_insert = reg_out;
          to_register = bram_out;
        end else begin
          bram_insert = bram_out;
          to_register = reg_out;
        end
      end
      REM_CMP: begin
        bram_insert = bram_out;
        to_register = reg_out;
      end
      INS_CMT: begin
        if (array_cnt_in < array_size)
          array_cnt_out = array_cnt_in + 8'd1;
      end
      REM_CMT: begin
        if (array_cnt_in != 8'd0)
          array_cnt_out = array_cnt_in - 8'd1;
      end
      default: begin
        array_cnt_out = array_cnt_in;
      end
    endcase
  end

endmodule

// File: rtl/queue_sequencer.sv
// Min-priority queue sequencer over a single-port BRAM, sorted ascending.
// Ports: op_* request, rsp_* completion, bram_* memory, count/full/empty status.
module queue_sequencer
  import quickq_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic          op_type,
  input  logic [DW-1:0] op_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [7:0]    bram_addr,
  output logic          bram_we,
  output logic [DW-1:0] bram_wdata,
  input  logic [DW-1:0] bram_rdata,
  output logic [7:0]    count,
  output logic          full,
  output logic          empty
);

  localparam logic [DW-1:0] SENT   = SENTINEL[DW-1:0];
  localparam logic [7:0]    DEPTH8 = 8'(DEPTH);

  state_e        state_q, state_d;
  logic [7:0]    i_q, i_d;
  logic [7:0]    count_q, count_d;
  logic [DW-1:0] carry_q, carry_d;
  logic [DW-1:0] head_q, head_d;
  logic          pop_q, pop_d;

  mode_e         mode;
  logic [DW-1:0] r_bram, r_reg;
  logic [DW-1:0] r_ins, r_to_reg;
  logic [7:0]    r_cnt;
  logic [7:0]    i_inc;
  logic          bad_op;

  assign i_inc      = i_q + 8'd1;
  assign count      = count_q;
  assign full       = (count_q == DEPTH8);
  assign empty      = (count_q == 8'd0);
  assign bram_wdata = r_ins;
  assign bad_op     = op_type ? empty : full;

  valueRouter #(.DW(DW)) u_router (
    .mode          (mode),
    .bram_out      (r_bram),
    .reg_out       (r_reg),
    .array_size    (DEPTH8),
    .array_cnt_in  (count_q),
    .bram_insert   (r_ins),
    .to_register   (r_to_reg),
    .array_cnt_out (r_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      count_q <= 8'd0;
      carry_q <= SENT;
      head_q  <= SENT;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      count_q <= count_d;
      carry_q <= carry_d;
      head_q  <= head_d;
      pop_q   <= pop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    count_d   = count_q;
    carry_d   = carry_q;
    head_d    = head_q;
    pop_d     = pop_q;
    op_ready  = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = SENT;
    bram_addr = 8'd0;
    bram_we   = 1'b0;
    mode      = INS_CMP;
    r_bram    = SENT;
    r_reg     = SENT;
    unique case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          pop_d = op_type;
          if (bad_op) begin
            state_d = ERR;
          end else if (op_type) begin
            state_d = HEAD_RD;
          end else begin
            carry_d = op_data;
            i_d     = 8'd0;
            state_d = RD;
          end
        end
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = IDLE;
      end
      HEAD_RD: begin
        bram_addr = 8'd0;
        state_d   = HEAD;
      end
      HEAD: begin
        head_d  = bram_rdata;
        i_d     = 8'd0;
        state_d = RD;
      end
      RD: begin
        // Pop shifts slot i+1 down into slot i.
        bram_addr = pop_q ? i_inc : i_q;
        state_d   = CMP;
      end
      CMP: begin
        bram_addr = i_q;
        bram_we   = 1'b1;
        if (pop_q) begin
          mode   = REM_CMP;
          r_bram = (i_inc == count_q) ? SENT : bram_rdata;
          r_reg  = head_q;
          if (i_inc == count_q) begin
            state_d = CMT;
          end else begin
            i_d     = i_inc;
            state_d = RD;
          end
        end else begin
          mode    = INS_CMP;
          r_bram  = (i_q == count_q) ? SENT : bram_rdata;
          r_reg   = carry_q;
          carry_d = r_to_reg;
          if (i_q == count_q) begin
            state_d = CMT;
          end else begin
            i_d     = i_inc;
            state_d = RD;
          end
        end
      end
      CMT: begin
        mode    = pop_q ? REM_CMT : INS_CMT;
        count_d = r_cnt;
        state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        rsp_data  = pop_q ? head_q : SENT;
        state_d   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_queue_sequencer.sv
// Scoreboard bench for queue_sequencer with a behavioural BRAM.
// Stimulus queues expected responses; a monitor checks them on rsp_valid.
module tb_queue_sequencer;

  localparam int DW = 32;
  localparam logic [31:0] SEN = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst_n;
  logic          op_valid;
  logic          op_ready;
  logic          op_type;
  logic [DW-1:0] op_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [7:0]    bram_addr;
  logic          bram_we;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata;
  logic [7:0]    count;
  logic          full;
  logic          empty;

  queue_sequencer #(.DEPTH(5), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_type    (op_type),
    .op_data    (op_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  logic [31:0] mem [256];
  int          cyc;
  int          tests;
  int          fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cyc);
      end else begin
        me = sb.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(me.data));
        chk("rsp_err", 64'(rsp_err), 64'(me.err));
        chk("rsp_cycle", 64'(cyc), 64'(me.due));
      end
    end
  end

  task automatic op(input logic t, input logic [31:0] d,
                    input logic [31:0] ed, input logic ee,
                    input int lat);
    @(negedge clk);
    chk("op_ready", 64'(op_ready), 64'd1);
    op_valid = 1'b1;
    op_type  = t;
    op_data  = d;
    sb.push_back('{ed, ee, cyc + lat});
    @(negedge clk);
    op_valid = 1'b0;
    for (int k = 0; k < 60 && sb.size() != 0; k++)
      @(negedge clk);
    chk("rsp_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic push(input logic [31:0] d, input int lat);
    op(1'b0, d, SEN, 1'b0, lat);
  endtask

  task automatic pop(input logic [31:0] ed, input int lat);
    op(1'b1, 32'h0, ed, 1'b0, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_type  = 1'b0;
    op_data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ready", 64'(op_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);

    push(32'd2, 4);
    chk("push2_count", 64'(count), 64'd1);
    chk("push2_mem0", 64'(mem[0]), 64'd2);
    pop(32'd2, 6);
    chk("pop2_count", 64'(count), 64'd0);

    push(32'd7, 4);
    push(32'd3, 6);
    push(32'd9, 8);
    pop(32'd3, 10);
    pop(32'd7, 8);
    pop(32'd9, 6);
    chk("order_count", 64'(count), 64'd0);
    chk("order_empty", 64'(empty), 64'd1);

    push(32'h50, 4);
    push(32'h10, 6);
    push(32'h40, 8);
    push(32'h20, 10);
    push(32'h30, 12);
    chk("fill_count", 64'(count), 64'd5);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_mem0", 64'(mem[0]), 64'h10);
    chk("fill_mem2", 64'(mem[2]), 64'h30);
    chk("fill_mem4", 64'(mem[4]), 64'h50);
    op(1'b0, 32'h11, SEN, 1'b1, 1);
    chk("ovf_count", 64'(count), 64'd5);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_mem1", 64'(mem[1]), 64'h20);

    pop(32'h10, 14);
    chk("popfull_mem0", 64'(mem[0]), 64'h20);
    chk("popfull_mem4", 64'(mem[4]), 64'(SEN));
    chk("popfull_count", 64'(count), 64'd4);
    pop(32'h20, 12);
    pop(32'h30, 10);
    pop(32'h40, 8);
    pop(32'h50, 6);
    chk("drain_empty", 64'(empty), 64'd1);

    op(1'b1, 32'h0, SEN, 1'b1, 1);
    chk("udf_count", 64'(count), 64'd0);

    push(32'd1, 4);
    push(32'd8, 6);
    chk("pre_rst_count", 64'(count), 64'd2);
    @(negedge clk);
    op_valid = 1'b1;
    op_type  = 1'b0;
    op_data  = 32'd5;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_we", 64'(bram_we), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_ready", 64'(op_ready), 64'd1);
    push(32'd4, 4);
    chk("postrst_count", 64'(count), 64'd1);
    chk("postrst_mem0", 64'(mem[0]), 64'd4);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
